// File: rtl/alu_pkg.sv
// Shared types and RV32I decode constants for the execute-stage sequencer.
package alu_pkg;

  // ALU operation codes driven onto ALU_operation
  typedef enum logic [4:0] {
    ALU_NONE = 5'b00000,
    ALU_ADD  = 5'b00001,
    ALU_SUB  = 5'b00010,
    ALU_AND  = 5'b00100,
    ALU_OR   = 5'b00101,
    ALU_LT   = 5'b00110,
    ALU_GE   = 5'b00111,
    ALU_XOR  = 5'b01001,
    ALU_EQ   = 5'b01010
  } alu_op_t;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 for ALU ops
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // funct3 for branches
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // funct7
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/imm_gen.sv
// Sign-extended I-type and B-type immediates from a raw RV32I word.
module imm_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_b
);

  // Bits not carrying any immediate field for these formats
  logic unused_bits;
  assign unused_bits = ^{instr[19:12], instr[6:0]};

  // Immediate field extraction
  always_comb begin
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute sequencer: decodes one instruction, drives the external
// ALU, samples its result and reports a writeback or branch decision.
module alu_exec_sequencer
  import alu_pkg::*;
#(
  parameter int tamanyo = 32,
  parameter int OPW     = 5
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  input  logic [31:0]        pc,
  input  logic [tamanyo-1:0] rs1_data,
  input  logic [tamanyo-1:0] rs2_data,
  output logic [OPW-1:0]     ALU_operation,
  output logic [tamanyo-1:0] A,
  output logic [tamanyo-1:0] B,
  input  logic [tamanyo-1:0] res,
  input  logic               zero,
  output logic               done,
  output logic               wb_en,
  output logic [4:0]         wb_rd,
  output logic [tamanyo-1:0] wb_data,
  output logic               br_taken,
  output logic [31:0]        br_target,
  output logic               illegal
);

  state_t             state, state_nx;
  logic               accept;
  logic [31:0]        instr_q, pc_q;
  logic [tamanyo-1:0] rs1_q, rs2_q, res_q;
  logic               zero_q;
  logic [31:0]        imm_i, imm_b, target_q;
  alu_op_t            op_d;
  logic               use_imm, is_br, br_inv, ill;
  logic               is_br_q, br_inv_q, ill_q;
  logic [2:0]         f3;
  logic [6:0]         f7;

  assign accept = instr_valid && instr_ready && (state == S_IDLE);
  assign f3     = instr_q[14:12];
  assign f7     = instr_q[31:25];

  imm_gen u_imm_gen (
    .instr (instr_q),
    .imm_i (imm_i),
    .imm_b (imm_b)
  );

  // State register
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; illegal instructions bypass EXEC
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = S_DECODE;
      S_DECODE: state_nx = ill ? S_RESP : S_EXEC;
      S_EXEC:   state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Instruction decode of the captured word
  always_comb begin
    op_d    = ALU_NONE;
    use_imm = 1'b0;
    is_br   = 1'b0;
    br_inv  = 1'b0;
    ill     = 1'b0;
    case (instr_q[6:0])
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD:  op_d = ALU_ADD;
            F3_XOR:  op_d = ALU_XOR;
            F3_OR:   op_d = ALU_OR;
            F3_AND:  op_d = ALU_AND;
            default: ill  = 1'b1;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          op_d = ALU_SUB;
        end else begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        case (f3)
          F3_ADD:  op_d = ALU_ADD;
          F3_XOR:  op_d = ALU_XOR;
          F3_OR:   op_d = ALU_OR;
          F3_AND:  op_d = ALU_AND;
          default: ill  = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        is_br = 1'b1;
        case (f3)
          F3_BEQ:  op_d = ALU_EQ;
          F3_BNE:  begin op_d = ALU_EQ; br_inv = 1'b1; end
          F3_BLT:  op_d = ALU_LT;
          F3_BGE:  op_d = ALU_GE;
          default: ill  = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  end

  // Capture, operand setup and result sampling
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      instr_ready   <= 1'b0;
      instr_q       <= '0;
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      ALU_operation <= '0;
      A             <= '0;
      B             <= '0;
      target_q      <= '0;
      is_br_q       <= 1'b0;
      br_inv_q      <= 1'b0;
      ill_q         <= 1'b0;
      res_q         <= '0;
      zero_q        <= 1'b0;
    end else begin
      instr_ready <= (state_nx == S_IDLE);
      if (accept) begin
        instr_q <= instr;
        pc_q    <= pc;
        rs1_q   <= rs1_data;
        rs2_q   <= rs2_data;
      end
      if (state == S_DECODE) begin
        ALU_operation <= OPW'(op_d);
        A             <= rs1_q;
        B             <= use_imm ? imm_i[tamanyo-1:0] : rs2_q;
        target_q      <= pc_q + imm_b;
        is_br_q       <= is_br;
        br_inv_q      <= br_inv;
        ill_q         <= ill;
        if (ill) begin
          res_q  <= '0;
          zero_q <= 1'b0;
        end
      end
      if (state == S_EXEC) begin
        res_q  <= res;
        zero_q <= zero;
      end
    end
  end

  // Response registers, updated only when leaving RESP so they hold between instructions
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      done      <= 1'b0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
      illegal   <= 1'b0;
    end else begin
      done <= (state == S_RESP);
      if (state == S_RESP) begin
        wb_en     <= !ill_q && !is_br_q && (instr_q[11:7] != 5'd0);
        wb_rd     <= instr_q[11:7];
        wb_data   <= res_q;
        br_taken  <= !ill_q && is_br_q && (zero_q ^ br_inv_q);
        br_target <= target_q;
        illegal   <= ill_q;
      end
    end
  end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multi-cycle execute-stage sequencer for the RV32I core; it drives the combinational ALU and consumes its result.
- Accepts one decoded-register instruction per handshake, generates ALU_operation and the A/B operands, and samples res/zero.
- Produces either a register writeback or a branch decision with its target.
- Sits between the register-file read stage and the writeback/PC-update logic.

Parameters:
- tamanyo, 32: datapath width. Must be 32 for RV32I.
- OPW, 5: ALU_operation width.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTa  in  1  asynchronous active-low reset.
- instr_valid  in  1  upstream has an instruction.
- instr_ready  out  1  sequencer can accept.
- instr  in  32  raw RV32I instruction word.
- pc  in  32  PC of instr.
- rs1_data  in  32  rs1 register value.
- rs2_data  in  32  rs2 register value.
- ALU_operation  out  5  op code to ALU.
- A  out  32  ALU operand 1.
- B  out  32  ALU operand 2.
- res  in  32  ALU result.
- zero  in  1  ALU flag.
- done  out  1  one-cycle completion pulse.
- wb_en  out  1  write rd, qualified by done.
- wb_rd  out  5  destination register.
- wb_data  out  32  writeback value.
- br_taken  out  1  branch taken, qualified by done.
- br_target  out  32  pc + B-immediate.
- illegal  out  1  unsupported instruction, qualified by done.

Behaviour:
- Reset (RSTa=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including instr_ready, ALU_operation, A and B.
  - instr_ready rises the first cycle after RSTa deasserts.
- FSM states: IDLE -> DECODE -> EXEC -> RESP -> IDLE.
- IDLE:
  - instr_ready=1.
  - On a rising edge with instr_valid&&instr_ready, capture instr, pc, rs1_data and rs2_data, then go to DECODE.
  - instr_ready=0 in every other state.
- DECODE:
  - Register ALU_operation, A and B.
  - Register B-imm target = pc + sext(imm_b), computed by a local adder, not the ALU.
  - Unsupported opcode or funct: go to RESP with illegal=1 and skip EXEC.
- EXEC:
  - ALU inputs are stable for the whole cycle.
  - At the end of EXEC, sample res and zero into the result registers.
- RESP:
  - done=1 for exactly one cycle, then return to IDLE.
  - Outputs hold their values until the next RESP.
- Latency: accept at edge k; done is high in the cycle after edge k+3. Illegal instructions: done after edge k+2. Throughput is one instruction per 4 cycles.
- Op encoding:
  - ADD 00001, SUB 00010, AND 00100, OR 00101, XOR 01001.
  - LT 00110: zero=1 iff A<B, signed.
  - GE 00111: zero=1 iff A>=B, signed.
  - EQ 01010: zero=1 iff A==B.
  - For LT, GE and EQ the ALU res is 0.
- Supported instructions:
  - R-type ADD, SUB, AND, OR, XOR: A=rs1, B=rs2.
  - I-type ADDI, ANDI, ORI, XORI: A=rs1, B=sext(imm_i).
  - BEQ: EQ, taken if zero.
  - BNE: EQ, taken if !zero.
  - BLT: LT, taken if zero.
  - BGE: GE, taken if zero.
- Writeback:
  - wb_en=1 for ALU instructions with rd!=0.
  - wb_en=0 for branches, illegal instructions, and rd=0.
  - wb_data=res.
- Branch output: br_taken=0 for non-branches. Arithmetic is modulo 2^32 and overflow is ignored.
- instr_valid outside IDLE is ignored and not consumed; upstream holds it.
- Reset mid-operation aborts with no done pulse.

Decomposition:
- alu_pkg:
  - alu_op_t enum with the codes above.
  - RV32I opcode constants: OP 0110011, OP_IMM 0010011, BRANCH 1100011.
  - funct3/funct7 constants.
  - state_t enum.
- Sub-module imm_gen (combinational): outputs sext imm_i and imm_b from instr.

Test Plan:
1. ADD x3,x1,x2:
   - Stimulus: 0x002081B3, rs1=5, rs2=7.
   - Response: done 4 cycles after accept, wb_en=1, wb_rd=3, wb_data=12.
2. SUB:
   - Stimulus: 0x402081B3, rs1=5, rs2=7.
   - Response: ALU_operation=00010, wb_data=0xFFFFFFFE.
3. ADDI x5,x0,-1:
   - Stimulus: 0xFFF00293, rs1=0.
   - Response: B=0xFFFFFFFF, wb_data=0xFFFFFFFF, wb_rd=5.
4. BEQ and BLT:
   - Stimulus: BEQ 0x00208463, pc=0x100, rs1=rs2=9.
   - Response: br_taken=1, br_target=0x108, wb_en=0.
   - Stimulus: BLT 0x0020C463, rs1=0xFFFFFFFF, rs2=1.
   - Response: br_taken=1 (signed).
5. Illegal instruction:
   - Stimulus: 0x00000000.
   - Response: done with illegal=1 three cycles after accept, wb_en=0, br_taken=0.
6. Reset mid-operation:
   - Stimulus: assert RSTa=0 during EXEC.
   - Response: outputs 0 immediately, no done pulse; instr_ready=1 one cycle after release.
